// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - OP_* : funct3 encodings of the M-extension operations
//   - state_e : sequencer FSM states
//   - res_sel_e : which datapath half the final result is taken from
//   - neg_ext : two's-complement negate on a wide word; callers sign- or
//     zero-extend into it so the magnitude of 100..0 stays representable,
//     then cast back down to their own width.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // RES_LO     : product low half or quotient (plain negate)
    // RES_HI_MUL : product high half (negate borrows from the low half)
    // RES_HI_REM : remainder (plain negate)
    typedef enum logic [1:0] {
        RES_LO     = 2'd0,
        RES_HI_MUL = 2'd1,
        RES_HI_REM = 2'd2
    } res_sel_e;

    // Supports any WIDTH up to NEG_MAX_W; the extra bit over 64 keeps the
    // negate exact for a sign-extended 100..0 operand.
    localparam int NEG_MAX_W = 64;
    localparam int NEG_W     = NEG_MAX_W + 1;

    function automatic logic [NEG_W-1:0] neg_ext(input logic [NEG_W-1:0] v);
        return ~v + NEG_W'(1);
    endfunction

endpackage

// File: rtl/muldiv_dp.sv
// muldiv_dp: radix-2 datapath for muldiv_seq.
//   Registers: hi (product high / partial remainder), lo (multiplier being
//   consumed / dividend becoming quotient), b (multiplicand / divisor), result.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load_i, is_div_i    load magnitudes and select multiply or divide mode
//   a_mag_i, b_mag_i    |rs1|, |rs2| (unsigned magnitudes)
//   step_i              perform one iteration
//   fix_i, sel_i, neg_i capture the selected, optionally negated, result
//   spec_i, spec_val_i  capture a precomputed result (special cases)
//   result_o            registered result
module muldiv_dp
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_mag_i,
    input  logic [WIDTH-1:0] b_mag_i,
    input  logic             step_i,
    input  logic             fix_i,
    input  res_sel_e         sel_i,
    input  logic             neg_i,
    input  logic             spec_i,
    input  logic [WIDTH-1:0] spec_val_i,
    output logic [WIDTH-1:0] result_o
);

    logic [WIDTH-1:0] hi_q, lo_q, b_q, res_q;
    logic [WIDTH-1:0] hi_d, lo_d, fix_val;
    logic             div_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic             fits;

    // One iteration. Multiply: add b into the high half when the current
    // multiplier bit is set, then shift the whole product right (the carry
    // out of the add becomes the new top bit). Divide: shift the next
    // dividend bit into the remainder, subtract the divisor if it fits.
    always_comb begin
        sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rem_sh = {hi_q, lo_q[WIDTH-1]};
        fits   = (rem_sh >= {1'b0, b_q});
        if (div_q) begin
            hi_d = fits ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], fits};
        end else begin
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Negating the high half of a 2*WIDTH product: ~hi plus the carry that
    // ripples out of the low half, which happens only when lo is zero.
    always_comb begin
        fix_val = lo_q;
        case (sel_i)
            RES_LO:     fix_val = neg_i ? WIDTH'(neg_ext(NEG_W'(lo_q))) : lo_q;
            RES_HI_MUL: fix_val = neg_i ? (~hi_q + WIDTH'(lo_q == '0)) : hi_q;
            RES_HI_REM: fix_val = neg_i ? WIDTH'(neg_ext(NEG_W'(hi_q))) : hi_q;
            default:    fix_val = lo_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            res_q <= '0;
        end else begin
            if (load_i) begin
                hi_q  <= '0;
                lo_q  <= is_div_i ? a_mag_i : b_mag_i;
                b_q   <= is_div_i ? b_mag_i : a_mag_i;
                div_q <= is_div_i;
            end else if (step_i) begin
                hi_q <= hi_d;
                lo_q <= lo_d;
            end
            if (fix_i) begin
                res_q <= fix_val;
            end else if (spec_i) begin
                res_q <= spec_val_i;
            end
        end
    end

    assign result_o = res_q;

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer (top).
//   IDLE -> PREP -> CALC (WIDTH cycles) -> FIX -> DONE, with divide-by-zero
//   and signed overflow resolved in PREP and sent straight to DONE.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                abort any in-flight op, result discarded
//   in_valid/in_ready    request handshake (ready only in IDLE)
//   op, rs1, rs2         funct3 and operands
//   out_valid/out_ready  result handshake, result held while out_valid
//   result               registered result
//   busy                 state is not IDLE
// Build option: MULDIV_EARLY_OUT_EN resolves a zero multiply operand, or a
// divide whose dividend magnitude is below the divisor's, in PREP.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;

    logic             is_div, is_rem, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, div_ovf;
    res_sel_e         sel;
    logic             dp_load, dp_step, dp_fix, dp_spec;
    logic [WIDTH-1:0] spec_val;

    // Operand classification from the latched request.
    always_comb begin
        is_div   = op_q[2];
        is_rem   = op_q[2] & op_q[1];
        a_neg    = a_q[WIDTH-1] & ((op_q == OP_MULH) | (op_q == OP_MULHSU) |
                                   (op_q == OP_DIV)  | (op_q == OP_REM));
        b_neg    = b_q[WIDTH-1] & ((op_q == OP_MULH) | (op_q == OP_DIV) |
                                   (op_q == OP_REM));
        a_mag    = a_neg ? WIDTH'(neg_ext(NEG_W'($signed(a_q)))) : a_q;
        b_mag    = b_neg ? WIDTH'(neg_ext(NEG_W'($signed(b_q)))) : b_q;
        div_zero = is_div & (b_q == '0);
        div_ovf  = ((op_q == OP_DIV) | (op_q == OP_REM)) &
                   (a_q == {1'b1, {(WIDTH-1){1'b0}}}) & (b_q == '1);
        if (!is_div) begin
            sel = (op_q == OP_MUL) ? RES_LO : RES_HI_MUL;
        end else begin
            sel = is_rem ? RES_HI_REM : RES_LO;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        dp_load  = 1'b0;
        dp_step  = 1'b0;
        dp_fix   = 1'b0;
        dp_spec  = 1'b0;
        spec_val = '0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    a_d     = rs1;
                    b_d     = rs2;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                // Remainder follows the dividend's sign; everything else
                // follows the sign product.
                neg_d = is_rem ? a_neg : (a_neg ^ b_neg);
                if (div_zero) begin
                    dp_spec  = 1'b1;
                    spec_val = is_rem ? a_q : '1;
                    state_d  = ST_DONE;
                end else if (div_ovf) begin
                    dp_spec  = 1'b1;
                    spec_val = is_rem ? '0 : a_q;
                    state_d  = ST_DONE;
                end
`ifdef MULDIV_EARLY_OUT_EN
                else if (!is_div && ((a_q == '0) || (b_q == '0))) begin
                    dp_spec  = 1'b1;
                    spec_val = '0;
                    state_d  = ST_DONE;
                end else if (is_div && (a_mag < b_mag)) begin
                    dp_spec  = 1'b1;
                    spec_val = is_rem ? a_q : '0;
                    state_d  = ST_DONE;
                end
`endif
                else begin
                    dp_load = 1'b1;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                dp_step = 1'b1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                dp_fix  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Flush drops a coinciding request and abandons anything in flight.
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

    muldiv_dp #(.WIDTH(WIDTH)) u_dp (
        .clk        (clk),
        .rst        (rst),
        .load_i     (dp_load),
        .is_div_i   (is_div),
        .a_mag_i    (a_mag),
        .b_mag_i    (b_mag),
        .step_i     (dp_step),
        .fix_i      (dp_fix),
        .sel_i      (sel),
        .neg_i      (neg_q),
        .spec_i     (dp_spec),
        .spec_val_i (spec_val),
        .result_o   (result)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed-vector bench for muldiv_seq (WIDTH=32).
// Latency is reported as the clock edge, counted from the accept edge (0),
// at which the consumer first samples out_valid high.
module tb_muldiv_seq;

    localparam int LN = 35;   // normal path
    localparam int LS = 2;    // divide-by-zero / signed overflow
`ifdef MULDIV_EARLY_OUT_EN
    localparam int LE = 2;    // early-out eligible operands
`else
    localparam int LE = 35;
`endif
    localparam int NV = 19;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic        in_ready, out_valid, busy;
    logic [31:0] result;

    int n_total = 0;
    int n_bad   = 0;
    int lat;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    logic [2:0]  v_op  [NV] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                3'd4, 3'd6, 3'd4, 3'd7, 3'd5, 3'd6, 3'd0, 3'd4, 3'd6};
    logic [31:0] v_a   [NV] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                32'h12345678, 32'h12345678, 32'h80000000, 32'h80000000,
                                32'h80000000, 32'd100, 32'd5, 32'hFFFFFFFD, 32'd0,
                                32'd7, 32'hFFFFFFFB};
    logic [31:0] v_b   [NV] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'h80000000, 32'hFFFFFFFF,
                                32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'd2, 32'd7, 32'd10, 32'd10, 32'd5, 32'hFFFFFFFE, 32'd0};
    logic [31:0] v_exp [NV] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF,
                                32'h40000000, 32'h80000000, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'h00000000,
                                32'hC0000000, 32'd2, 32'd0, 32'hFFFFFFFD, 32'd0,
                                32'hFFFFFFFD, 32'hFFFFFFFB};
    int          v_lat [NV] = '{LN, LN, LN, LN, LN, LN, LN, LN, LS, LS,
                                LS, LS, LN, LN, LE, LE, LE, LN, LS};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Presents a request for one edge; returns at #1 after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        op       = o;
        rs1      = a;
        rs2      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Bounded wait for out_valid; -1 means it never came.
    task automatic wait_valid(output int l);
        int cyc;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        l = (out_valid === 1'b1) ? cyc + 1 : -1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; rs1 = '0; rs2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_result",    result,         32'd0);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            issue(v_op[i], v_a[i], v_b[i]);
            wait_valid(lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(v_lat[i]));
            chk($sformatf("v%0d_result", i), result, v_exp[i]);
            $display("txn v%0d op=%0d a=%h b=%h result=%h lat=%0d", i, v_op[i], v_a[i], v_b[i], result, lat);
            consume();
            chk($sformatf("v%0d_after_ov", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: DIVU 100/7 held in DONE with a new request waiting
        issue(3'd5, 32'd100, 32'd7);
        wait_valid(lat);
        chk("bp_lat", 32'(lat), 32'd35);
        chk("bp_result", result, 32'd14);
        in_valid = 1'b1; op = 3'd0; rs1 = 32'd3; rs2 = 32'd5;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_ov", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_res", k), result, 32'd14);
            chk($sformatf("bp_hold%0d_ir", k), 32'(in_ready), 32'd0);
        end
        $display("txn backpressure op=5 a=%h b=%h result=%h lat=%0d", 32'd100, 32'd7, result, lat);
        consume();
        chk("bp_idle_ir", 32'(in_ready), 32'd1);
        chk("bp_idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accept_busy", 32'(busy), 32'd1);
        wait_valid(lat);
        chk("bp_mul_lat", 32'(lat), 32'd35);
        chk("bp_mul_result", result, 32'd15);
        $display("txn bp_next op=0 a=%h b=%h result=%h lat=%0d", 32'd3, 32'd5, result, lat);
        consume();

        // Flush at cycle 20 of a DIV, then MUL 3x5 and MUL 0x5
        issue(3'd4, 32'd1000, 32'd7);
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        chk("fl_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        $display("txn flush op=4 a=%h b=%h dropped", 32'd1000, 32'd7);
        issue(3'd0, 32'd3, 32'd5);
        wait_valid(lat);
        chk("fl_mul_lat", 32'(lat), 32'd35);
        chk("fl_mul_result", result, 32'd15);
        $display("txn fl_mul op=0 a=%h b=%h result=%h lat=%0d", 32'd3, 32'd5, result, lat);
        consume();
        issue(3'd0, 32'd0, 32'd5);
        wait_valid(lat);
        chk("fl_mul0_lat", 32'(lat), 32'(LE));
        chk("fl_mul0_result", result, 32'd0);
        $display("txn fl_mul0 op=0 a=%h b=%h result=%h lat=%0d", 32'd0, 32'd5, result, lat);
        consume();

        // Flush coinciding with accept: request dropped
        flush = 1'b1;
        issue(3'd0, 32'd2, 32'd2);
        flush = 1'b0;
        chk("fa_busy", 32'(busy), 32'd0);
        chk("fa_in_ready", 32'(in_ready), 32'd1);
        $display("txn flush_accept op=0 dropped");

        // Flush with out_ready in DONE: consumed, no replay
        issue(3'd5, 32'd9, 32'd0);
        wait_valid(lat);
        chk("fd_lat", 32'(lat), 32'd2);
        chk("fd_result", result, 32'hFFFFFFFF);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        out_ready = 1'b0;
        chk("fd_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("fd_no_replay", 32'(out_valid), 32'd0);
        chk("fd_busy", 32'(busy), 32'd0);
        $display("txn flush_done op=5 result consumed");

        // Reset in the middle of CALC
        issue(3'd5, 32'd1000, 32'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        chk("mr_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_result", result, 32'd0);
        $display("txn mid_reset op=5 aborted");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
